// File: rtl/dram_ctrl_pkg.sv
// Shared definitions for the two-port DRAM controller: state encoding,
// default geometry of the 4x72 DRAM and port index constants.
package dram_ctrl_pkg;

  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 72;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin pick. With both requests present the
// port that did not win last time is chosen.
module rr_arbiter_2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_idx_o
);

  // Single requester wins outright; contention goes to the other port.
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = 1'b0;
    if (req_i == 2'b11) begin
      gnt_idx_o = ~last_grant_i;
    end else begin
      gnt_idx_o = req_i[1];
    end
  end

endmodule

// File: rtl/dram_arbiter_2p.sv
// Two-port controller sharing one 4x72 DRAM. Each access takes three
// cycles (IDLE grant, ISSUE drive, DONE ack); outputs are registered
// except busy, which decodes the state.
module dram_arbiter_2p
  import dram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e              state_q;
  logic                last_grant_q;
  logic                grantee_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_we_q;
  logic                p0_ack_q;
  logic                p1_ack_q;
  logic [DATA_W-1:0]   p0_rdata_q;
  logic [DATA_W-1:0]   p1_rdata_q;
  logic                gnt_valid;
  logic                gnt_idx;

  rr_arbiter_2 u_arb (
    .req_i        ({p1_req, p0_req}),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_idx_o    (gnt_idx)
  );

  // Access FSM: latch the winner, drive the DRAM for one cycle, pulse ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT1;
      grantee_q    <= PORT0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      p0_ack_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            grantee_q <= gnt_idx;
            if (gnt_idx == PORT1) begin
              mem_addr_q  <= p1_addr;
              mem_wdata_q <= p1_wdata;
              mem_we_q    <= p1_we;
            end else begin
              mem_addr_q  <= p0_addr;
              mem_wdata_q <= p0_wdata;
              mem_we_q    <= p0_we;
            end
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // A write commits in the DRAM at this same edge.
          mem_we_q <= 1'b0;
          if (grantee_q == PORT1) begin
            p1_ack_q <= 1'b1;
            if (!mem_we_q) p1_rdata_q <= mem_rdata;
          end else begin
            p0_ack_q <= 1'b1;
            if (!mem_we_q) p0_rdata_q <= mem_rdata;
          end
          state_q <= DONE;
        end
        DONE: begin
          p0_ack_q     <= 1'b0;
          p1_ack_q     <= 1'b0;
          last_grant_q <= grantee_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dram_arbiter_2p.sv
// Bench for dram_arbiter_2p with a behavioural 4x72 DRAM attached.
module tb_dram_arbiter_2p;

  localparam int AW = 2;
  localparam int DW = 72;

  logic          clk;
  logic          rst;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ack, p1_ack;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;
  logic          busy;

  logic          mem_clr;
  logic [DW-1:0] dram [4];

  int n_cmp;
  int n_err;

  dram_arbiter_2p #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_ack    (p0_ack),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_ack    (p1_ack),
    .p1_rdata  (p1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DRAM: asynchronous read, write on the rising edge while mem_we is high.
  assign mem_rdata = dram[mem_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 4; k++) dram[k] <= '0;
    end else if (mem_we) begin
      dram[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    logic          rst;
    logic          r0;
    logic          w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1;
    logic          w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          e_ack0;
    logic          e_ack1;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic          e_busy;
    logic [DW-1:0] e_rd0;
    logic [DW-1:0] e_rd1;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  localparam logic [DW-1:0] Z   = 72'd0;
  localparam logic [DW-1:0] D12 = 72'd12;
  localparam logic [DW-1:0] DAA = 72'hAA;
  localparam logic [DW-1:0] D5  = 72'h5;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic r0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic r1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    rst = r; p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    mem_clr = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'd0, Z, 1'b0, 1'b0, 2'd0, Z);

    //            rst   r0    w0    a0    d0   r1    w1    a1    d1   ack0  ack1  we    addr  wdata busy  rd0  rd1
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, Z,   1'b0, 1'b0, 2'd0, Z,   1'b0, 1'b0, 1'b0, 2'd0, Z,   1'b0, Z,   Z};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 2'd2, D12, 1'b0, 1'b0, 2'd0, Z,   1'b0, 1'b0, 1'b1, 2'd2, D12, 1'b1, Z,   Z};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 2'd2, D12, 1'b0, 1'b0, 2'd0, Z,   1'b1, 1'b0, 1'b0, 2'd2, D12, 1'b1, Z,   Z};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, Z,   1'b0, 1'b0, 2'd0, Z,   1'b0, 1'b0, 1'b0, 2'd2, D12, 1'b0, Z,   Z};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd2, Z,   1'b0, 1'b0, 2'd0, Z,   1'b0, 1'b0, 1'b0, 2'd2, Z,   1'b1, Z,   Z};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 2'd2, Z,   1'b0, 1'b0, 2'd0, Z,   1'b1, 1'b0, 1'b0, 2'd2, Z,   1'b1, D12, Z};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, Z,   1'b0, 1'b0, 2'd0, Z,   1'b0, 1'b0, 1'b0, 2'd2, Z,   1'b0, D12, Z};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, Z,   1'b0, 1'b0, 2'd0, Z,   1'b0, 1'b0, 1'b0, 2'd2, Z,   1'b0, D12, Z};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, Z,   1'b0, 1'b0, 2'd0, Z,   1'b0, 1'b0, 1'b0, 2'd0, Z,   1'b0, Z,   Z};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 2'd1, DAA, 1'b1, 1'b0, 2'd1, Z,   1'b0, 1'b0, 1'b1, 2'd1, DAA, 1'b1, Z,   Z};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 2'd1, DAA, 1'b1, 1'b0, 2'd1, Z,   1'b1, 1'b0, 1'b0, 2'd1, DAA, 1'b1, Z,   Z};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 2'd0, Z,   1'b1, 1'b0, 2'd1, Z,   1'b0, 1'b0, 1'b0, 2'd1, DAA, 1'b0, Z,   Z};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 2'd0, Z,   1'b1, 1'b0, 2'd1, Z,   1'b0, 1'b0, 1'b0, 2'd1, Z,   1'b1, Z,   Z};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 2'd0, Z,   1'b1, 1'b0, 2'd1, Z,   1'b0, 1'b1, 1'b0, 2'd1, Z,   1'b1, Z,   DAA};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 2'd0, Z,   1'b0, 1'b0, 2'd0, Z,   1'b0, 1'b0, 1'b0, 2'd1, Z,   1'b0, Z,   DAA};

    tick();
    mem_clr = 1'b0;

    // Write, read-back and contention sequences, one row per clock.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      tick();
      chk($sformatf("row%0d p0_ack", i),    DW'(p0_ack),    DW'(tbl[i].e_ack0));
      chk($sformatf("row%0d p1_ack", i),    DW'(p1_ack),    DW'(tbl[i].e_ack1));
      chk($sformatf("row%0d mem_we", i),    DW'(mem_we),    DW'(tbl[i].e_we));
      chk($sformatf("row%0d mem_addr", i),  DW'(mem_addr),  DW'(tbl[i].e_addr));
      chk($sformatf("row%0d mem_wdata", i), mem_wdata,      tbl[i].e_wdata);
      chk($sformatf("row%0d busy", i),      DW'(busy),      DW'(tbl[i].e_busy));
      chk($sformatf("row%0d p0_rdata", i),  p0_rdata,       tbl[i].e_rd0);
      chk($sformatf("row%0d p1_rdata", i),  p1_rdata,       tbl[i].e_rd1);
    end

    // Fairness: both ports request continuously for six accesses.
    drive(1'b1, 1'b0, 1'b0, 2'd0, Z, 1'b0, 1'b0, 2'd0, Z);
    tick();
    drive(1'b0, 1'b1, 1'b0, 2'd0, Z, 1'b1, 1'b0, 2'd1, Z);
    for (int k = 0; k < 18; k++) begin
      tick();
      chk($sformatf("rr cyc%0d busy", k),   DW'(busy),   DW'((k % 3) != 2));
      chk($sformatf("rr cyc%0d p0_ack", k), DW'(p0_ack), DW'((k % 6) == 1));
      chk($sformatf("rr cyc%0d p1_ack", k), DW'(p1_ack), DW'((k % 6) == 4));
    end

    // Reset lands in the ISSUE cycle of a port 1 write.
    drive(1'b1, 1'b0, 1'b0, 2'd0, Z, 1'b0, 1'b0, 2'd0, Z);
    tick();
    drive(1'b0, 1'b0, 1'b0, 2'd0, Z, 1'b1, 1'b1, 2'd3, D5);
    tick();
    chk("abort issue mem_we",   DW'(mem_we),   DW'(1'b1));
    chk("abort issue mem_addr", DW'(mem_addr), DW'(2'd3));
    drive(1'b1, 1'b0, 1'b0, 2'd0, Z, 1'b0, 1'b0, 2'd0, Z);
    tick();
    chk("abort p1_ack",    DW'(p1_ack),   DW'(1'b0));
    chk("abort busy",      DW'(busy),     DW'(1'b0));
    chk("abort mem_we",    DW'(mem_we),   DW'(1'b0));
    chk("abort mem_addr",  DW'(mem_addr), DW'(2'd0));
    chk("abort mem_wdata", mem_wdata,     Z);
    chk("abort p0_rdata",  p0_rdata,      Z);
    chk("abort p1_rdata",  p1_rdata,      Z);
    drive(1'b0, 1'b0, 1'b0, 2'd0, Z, 1'b0, 1'b0, 2'd0, Z);
    tick();
    chk("abort later p1_ack", DW'(p1_ack), DW'(1'b0));
    chk("abort later busy",   DW'(busy),   DW'(1'b0));
    drive(1'b0, 1'b1, 1'b0, 2'd3, Z, 1'b0, 1'b0, 2'd0, Z);
    tick();
    tick();
    chk("rd3 p0_ack",   DW'(p0_ack), DW'(1'b1));
    chk("rd3 p0_rdata", p0_rdata,    D5);
    drive(1'b0, 1'b0, 1'b0, 2'd0, Z, 1'b0, 1'b0, 2'd0, Z);
    tick();

    // Port 0 drops req during ISSUE of a read; the access still completes.
    drive(1'b0, 1'b1, 1'b0, 2'd2, Z, 1'b0, 1'b0, 2'd0, Z);
    tick();
    chk("drop issue busy", DW'(busy), DW'(1'b1));
    drive(1'b0, 1'b0, 1'b0, 2'd0, Z, 1'b0, 1'b0, 2'd0, Z);
    tick();
    chk("drop p0_ack",   DW'(p0_ack), DW'(1'b1));
    chk("drop p0_rdata", p0_rdata,    D12);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("drop after%0d busy", k),   DW'(busy),   DW'(1'b0));
      chk($sformatf("drop after%0d p0_ack", k), DW'(p0_ack), DW'(1'b0));
      chk($sformatf("drop after%0d mem_we", k), DW'(mem_we), DW'(1'b0));
      chk($sformatf("drop after%0d rdata", k),  p0_rdata,    D12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
